pause_dim_ctl: RTL and testbench
================================

PAUSE_DIM_CTL -- requirements
Module: pause_dim_ctl

Interface
REQ-001 Parameter DIM_CYCLES, default 32'h0ABA9500, sets the clk_sys cycles of user pause before dimming (10 s at 18 MHz).
REQ-002 clk_sys  in  1  system clock; the only clock in the block.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pause_btn  in  1  level input for the user pause button (OR of both joysticks).
REQ-005 osd_status  in  1  OSD open.
REQ-006 osd_pause_en  in  1  OSD-open pause is enabled.
REQ-007 hs_access  in  1  hiscore module requests a game halt.
REQ-008 ce_pix  in  1  pixel enable strobe.
REQ-009 blank  in  1  horizontal or vertical blank active.
REQ-010 rgb_in  in  8  RGB332 pixel (r[7:5], g[4:2], b[1:0]).
REQ-011 pause  out  1  halt request to the game core.
REQ-012 dim  out  1  dimming active.
REQ-013 rgb_out  out  8  conditioned RGB332 pixel.

Function
REQ-014 pause_btn is registered once, and a rising edge is detected against that registered value; btn_rise is a one-cycle pulse.
REQ-015 The state machine has three states: RUN, PAUSED and DIMMED; reset state is RUN.
REQ-016 RUN moves to PAUSED on btn_rise.
REQ-017 PAUSED moves to RUN on btn_rise.
REQ-018 PAUSED moves to DIMMED when the timer equals DIM_CYCLES and btn_rise is absent.
REQ-019 DIMMED moves to RUN on btn_rise; otherwise it holds.
REQ-020 If btn_rise and the timer terminal condition occur in the same cycle, btn_rise wins and the next state is RUN.
REQ-021 The timer is 32-bit unsigned and clears to 0 on entry to PAUSED and in RUN.
REQ-022 The timer increments by 1 per cycle in PAUSED and saturates at DIM_CYCLES (no wrap).
REQ-023 The timer holds its value in DIMMED.
REQ-024 The timer is driven only by the user pause; hs_access and the OSD never start it.
REQ-025 pause is registered: pause equals hs_access OR (state != RUN) OR (osd_status AND osd_pause_en), sampled on the previous cycle, so latency is 1 cycle.
REQ-026 dim is registered and is high exactly when the state is DIMMED, with 1 cycle latency after the state change.
REQ-027 rgb_out updates only on cycles where ce_pix is high and holds otherwise, so latency is one ce_pix.
REQ-028 On an update with blank=1, rgb_out is 8'h00.
REQ-029 On an update with blank=0 and dim=1, each channel is shifted right by one independently: {r>>1, g>>1, b>>1}, with no borrow between fields.
REQ-030 On an update with blank=0 and dim=0, rgb_out equals rgb_in.
REQ-031 hs_access toggling during PAUSED or DIMMED does not change the state or the timer.

Reset
REQ-032 On reset the block goes to state RUN, timer=0, pause=0, dim=0, rgb_out=8'h00, and the button register=0.
REQ-033 Reset applied mid-PAUSED or mid-DIMMED gives those values on the next cycle, and a button held through reset does not produce a btn_rise.

Structure
REQ-034 The shared package galaga_pkg holds the state enum pause_state_t {RUN, PAUSED, DIMMED} and the constant DIM_CYCLES_DEFAULT.
REQ-035 The rising-edge detector is a separate sub-module, rise_detect, with ports clk_sys, reset, d and rise.
REQ-036 The remaining logic (state machine, timer, pixel stage) stays inline in pause_dim_ctl.

Verification
REQ-037 Scenario, pause then dim (DIM_CYCLES=16): reset, pulse pause_btn for 3 cycles -> pause=1 one cycle after the edge; dim=1 after 16 further cycles; rgb_in=8'hFF with blank=0 and ce_pix -> rgb_out=8'h6D.
REQ-038 Scenario, unpause from DIMMED: press the button again -> pause=0 and dim=0 one cycle after the state leaves DIMMED; rgb_in=8'hFF -> rgb_out=8'hFF.
REQ-039 Scenario, race: button edge in the same cycle the timer reaches DIM_CYCLES -> state RUN, and dim never asserts.
REQ-040 Scenario, external pause sources: hs_access=1 in RUN -> pause=1 and the timer stays 0; osd_status=1 with osd_pause_en=0 -> pause=0; with osd_pause_en=1 -> pause=1.
REQ-041 Scenario, reset mid-DIMMED with the button held high -> dim=0, pause=0 and state RUN; no toggle occurs until the button is released and pressed again.
REQ-042 Scenario, blanking and pixel enable: blank=1 with rgb_in=8'hFF -> rgb_out=8'h00; ce_pix=0 -> rgb_out holds its value.

Source files
------------

// File: rtl/galaga_pkg.sv
// Shared types and constants for the pause/dim control block.
// Holds the pause state enum and the default dim timeout.
package galaga_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        DIMMED = 2'd2
    } pause_state_t;

    // 10 s at 18 MHz
    localparam logic [31:0] DIM_CYCLES_DEFAULT = 32'h0ABA9500;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the user pause button.
// Ports: clk_sys, reset (sync, high), d (level in), rise (1-cycle pulse).
module rise_detect (
    input  logic clk_sys,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;
    // Set once d has been seen low after reset, so a button held
    // through reset never looks like a fresh press.
    logic armed;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            d_q   <= 1'b0;
            armed <= 1'b0;
        end else begin
            d_q   <= d;
            armed <= armed | ~d;
        end
    end

    assign rise = d & ~d_q & armed;

endmodule

// File: rtl/pause_dim_ctl.sv
// User pause with timed screen dimming, plus external halt sources.
// In: clk_sys, reset, pause_btn, osd_status, osd_pause_en, hs_access,
//     ce_pix, blank, rgb_in[7:0]. Out: pause, dim, rgb_out[7:0].
module pause_dim_ctl
    import galaga_pkg::*;
#(
    parameter logic [31:0] DIM_CYCLES = DIM_CYCLES_DEFAULT
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       pause_btn,
    input  logic       osd_status,
    input  logic       osd_pause_en,
    input  logic       hs_access,
    input  logic       ce_pix,
    input  logic       blank,
    input  logic [7:0] rgb_in,
    output logic       pause,
    output logic       dim,
    output logic [7:0] rgb_out
);

    pause_state_t state;
    logic [31:0]  timer;
    logic         btn_rise;

    rise_detect u_rise (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (pause_btn),
        .rise    (btn_rise)
    );

    // Only the user button drives the state and timer; hs_access and
    // the OSD just feed the pause output.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= RUN;
            timer <= 32'd0;
            pause <= 1'b0;
            dim   <= 1'b0;
        end else begin
            pause <= hs_access
                   | (state != RUN)
                   | (osd_status & osd_pause_en);
            dim   <= (state == DIMMED);
            unique case (state)
                RUN: begin
                    timer <= 32'd0;
                    if (btn_rise)
                        state <= PAUSED;
                end
                PAUSED: begin
                    if (btn_rise) begin
                        state <= RUN;
                        timer <= 32'd0;
                    end else if (timer == DIM_CYCLES) begin
                        state <= DIMMED;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                DIMMED: begin
                    if (btn_rise) begin
                        state <= RUN;
                        timer <= 32'd0;
                    end
                end
                default: begin
                    state <= RUN;
                    timer <= 32'd0;
                end
            endcase
        end
    end

    // Dimming halves each RGB332 field on its own, no borrow across.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rgb_out <= 8'h00;
        end else if (ce_pix) begin
            if (blank)
                rgb_out <= 8'h00;
            else if (dim)
                rgb_out <= {1'b0, rgb_in[7:6],
                            1'b0, rgb_in[4:3],
                            1'b0, rgb_in[1]};
            else
                rgb_out <= rgb_in;
        end
    end

endmodule

// File: tb/tb_pause_dim_ctl.sv
// Self-checking bench for pause_dim_ctl with a behavioural model.
// Scenario tasks plus a randomized run, one summary line at the end.
module tb_pause_dim_ctl;

    localparam logic [31:0] DIM = 32'd16;
    localparam int M_RUN = 0;
    localparam int M_PAU = 1;
    localparam int M_DIM = 2;

    logic       clk_sys;
    logic       reset;
    logic       pause_btn;
    logic       osd_status;
    logic       osd_pause_en;
    logic       hs_access;
    logic       ce_pix;
    logic       blank;
    logic [7:0] rgb_in;
    logic       pause;
    logic       dim;
    logic [7:0] rgb_out;

    int total = 0;
    int bad   = 0;

    pause_dim_ctl #(.DIM_CYCLES(DIM)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .pause_btn    (pause_btn),
        .osd_status   (osd_status),
        .osd_pause_en (osd_pause_en),
        .hs_access    (hs_access),
        .ce_pix       (ce_pix),
        .blank        (blank),
        .rgb_in       (rgb_in),
        .pause        (pause),
        .dim          (dim),
        .rgb_out      (rgb_out)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // ---------------- reference model ----------------
    logic        m_prev;
    logic        m_armed;
    int          m_mode;
    logic [31:0] m_count;
    logic        m_pause;
    logic        m_dim;
    logic [7:0]  m_rgb;
    logic        m_press;

    function automatic logic [7:0] dimf(input logic [7:0] x);
        int r, g, b;
        r = int'(x) / 32;
        g = (int'(x) / 4) % 8;
        b = int'(x) % 4;
        return 8'((r / 2) * 32 + (g / 2) * 4 + b / 2);
    endfunction

    assign m_press = pause_btn & ~m_prev & m_armed;

    always @(posedge clk_sys) begin
        if (reset) begin
            m_prev  <= 1'b0;
            m_armed <= 1'b0;
            m_mode  <= M_RUN;
            m_count <= 32'd0;
            m_pause <= 1'b0;
            m_dim   <= 1'b0;
            m_rgb   <= 8'h00;
        end else begin
            m_prev <= pause_btn;
            if (!pause_btn) m_armed <= 1'b1;
            m_pause <= hs_access || (m_mode != M_RUN)
                    || (osd_status && osd_pause_en);
            m_dim <= (m_mode == M_DIM);
            if (ce_pix)
                m_rgb <= blank ? 8'h00 : (m_dim ? dimf(rgb_in) : rgb_in);
            if (m_press) begin
                m_mode  <= (m_mode == M_RUN) ? M_PAU : M_RUN;
                m_count <= 32'd0;
            end else if (m_mode == M_PAU) begin
                if (m_count == DIM) m_mode <= M_DIM;
                else m_count <= m_count + 32'd1;
            end else if (m_mode == M_RUN) begin
                m_count <= 32'd0;
            end
        end
    end

    task automatic step();
        @(negedge clk_sys);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        pause_btn = 0; osd_status = 0; osd_pause_en = 0;
        hs_access = 0; ce_pix = 0; blank = 0; rgb_in = 8'h00;
        do_reset();
        total++;
        if (pause !== 1'b0 || dim !== 1'b0 || rgb_out !== 8'h00) begin
            bad++;
            $display("FAIL reset: pause=%b dim=%b rgb=%h want 0 0 00",
                     pause, dim, rgb_out);
        end
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_pause_dim();
        int n;
        pause_btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (pause !== m_pause || dim !== m_dim) begin
                bad++;
                $display("FAIL press: pause=%b dim=%b want %b %b",
                         pause, dim, m_pause, m_dim);
            end
        end
        pause_btn = 1'b0;
        total++;
        if (pause !== 1'b1) begin
            bad++;
            $display("FAIL paused: pause=%b want 1", pause);
        end
        n = 0;
        while (dim !== 1'b1 && n < 100) begin
            step();
            n++;
            total++;
            if (pause !== m_pause || dim !== m_dim) begin
                bad++;
                $display("FAIL dimwait: pause=%b dim=%b want %b %b",
                         pause, dim, m_pause, m_dim);
            end
        end
        total++;
        if (dim !== 1'b1) begin
            bad++;
            $display("FAIL dim_timeout: dim=%b want 1", dim);
        end
        rgb_in = 8'hFF; ce_pix = 1'b1;
        step();
        ce_pix = 1'b0;
        total++;
        if (rgb_out !== 8'h6D) begin
            bad++;
            $display("FAIL dim_rgb: rgb=%h want 6d", rgb_out);
        end
    endtask

    task automatic test_unpause();
        pause_btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (pause !== m_pause || dim !== m_dim) begin
                bad++;
                $display("FAIL unpause_seq: pause=%b dim=%b want %b %b",
                         pause, dim, m_pause, m_dim);
            end
        end
        pause_btn = 1'b0;
        total++;
        if (pause !== 1'b0 || dim !== 1'b0) begin
            bad++;
            $display("FAIL unpause: pause=%b dim=%b want 0 0", pause, dim);
        end
        rgb_in = 8'hFF; ce_pix = 1'b1;
        step();
        ce_pix = 1'b0;
        total++;
        if (rgb_out !== 8'hFF) begin
            bad++;
            $display("FAIL unpause_rgb: rgb=%h want ff", rgb_out);
        end
    endtask

    task automatic test_race();
        int  n;
        logic saw_dim;
        saw_dim = 1'b0;
        pause_btn = 1'b1;
        step();
        step();
        pause_btn = 1'b0;
        n = 0;
        while (!(m_mode == M_PAU && m_count == DIM) && n < 100) begin
            step();
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL race_timeout: cycles=%0d want <100", n);
        end
        pause_btn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (dim === 1'b1) saw_dim = 1'b1;
            total++;
            if (pause !== m_pause || dim !== m_dim) begin
                bad++;
                $display("FAIL race_seq: pause=%b dim=%b want %b %b",
                         pause, dim, m_pause, m_dim);
            end
        end
        pause_btn = 1'b0;
        total++;
        if (saw_dim !== 1'b0 || pause !== 1'b0) begin
            bad++;
            $display("FAIL race: saw_dim=%b pause=%b want 0 0",
                     saw_dim, pause);
        end
        step();
    endtask

    task automatic test_external();
        logic saw_dim;
        saw_dim = 1'b0;
        hs_access = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (dim === 1'b1) saw_dim = 1'b1;
        end
        total++;
        if (pause !== 1'b1 || saw_dim !== 1'b0) begin
            bad++;
            $display("FAIL hs_access: pause=%b saw_dim=%b want 1 0",
                     pause, saw_dim);
        end
        hs_access = 1'b0; osd_status = 1'b1; osd_pause_en = 1'b0;
        step();
        step();
        total++;
        if (pause !== 1'b0) begin
            bad++;
            $display("FAIL osd_off: pause=%b want 0", pause);
        end
        osd_pause_en = 1'b1;
        step();
        total++;
        if (pause !== 1'b1) begin
            bad++;
            $display("FAIL osd_on: pause=%b want 1", pause);
        end
        osd_status = 1'b0; osd_pause_en = 1'b0;
        step();
        total++;
        if (pause !== 1'b0) begin
            bad++;
            $display("FAIL osd_clear: pause=%b want 0", pause);
        end
    endtask

    task automatic test_reset_mid_dim();
        int n;
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        n = 0;
        while (dim !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        total++;
        if (dim !== 1'b1) begin
            bad++;
            $display("FAIL mid_dim_reach: dim=%b want 1", dim);
        end
        pause_btn = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (pause !== 1'b0 || dim !== 1'b0 || rgb_out !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset: pause=%b dim=%b rgb=%h want 0 0 00",
                     pause, dim, rgb_out);
        end
        for (int i = 0; i < 6; i++) step();
        total++;
        if (pause !== 1'b0) begin
            bad++;
            $display("FAIL held_btn: pause=%b want 0", pause);
        end
        pause_btn = 1'b0;
        step();
        step();
        pause_btn = 1'b1;
        step();
        step();
        total++;
        if (pause !== 1'b1) begin
            bad++;
            $display("FAIL repress: pause=%b want 1", pause);
        end
        pause_btn = 1'b0;
        step();
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        step();
        total++;
        if (pause !== 1'b0) begin
            bad++;
            $display("FAIL resume: pause=%b want 0", pause);
        end
    endtask

    task automatic test_blank_ce();
        blank = 1'b1; rgb_in = 8'hFF; ce_pix = 1'b1;
        step();
        total++;
        if (rgb_out !== 8'h00) begin
            bad++;
            $display("FAIL blank: rgb=%h want 00", rgb_out);
        end
        blank = 1'b0; rgb_in = 8'h5A;
        step();
        total++;
        if (rgb_out !== 8'h5A) begin
            bad++;
            $display("FAIL pass: rgb=%h want 5a", rgb_out);
        end
        ce_pix = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rgb_in = 8'($urandom);
            step();
            total++;
            if (rgb_out !== 8'h5A) begin
                bad++;
                $display("FAIL hold: rgb=%h want 5a", rgb_out);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) pause_btn = ~pause_btn;
            reset        = ($urandom_range(399) == 0);
            hs_access    = ($urandom_range(15) == 0);
            osd_status   = ($urandom_range(7) == 0);
            osd_pause_en = 1'($urandom);
            ce_pix       = 1'($urandom);
            blank        = ($urandom_range(3) == 0);
            rgb_in       = 8'($urandom);
            step();
            total++;
            if (pause !== m_pause || dim !== m_dim || rgb_out !== m_rgb) begin
                bad++;
                $display("FAIL random@%0d: got %b %b %h want %b %b %h", i,
                         pause, dim, rgb_out, m_pause, m_dim, m_rgb);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pause_btn = 0; osd_status = 0; osd_pause_en = 0;
        hs_access = 0; ce_pix = 0; blank = 0; rgb_in = 8'h00;
        test_reset();
        test_pause_dim();
        test_unpause();
        test_race();
        test_external();
        test_reset_mid_dim();
        test_blank_ce();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
